// File: rtl/serial_seq_transmitter_if.sv
// rtl/serial_seq_transmitter_if.sv - word input and serial output handshake bundle for serial_seq_transmitter
interface serial_seq_transmitter_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              seq;
    logic              valid;
    logic              out_ready;

    // master: the word source plus the downstream serial consumer
    modport master (
        output word_data, word_valid, out_ready,
        input  word_ready, seq, valid
    );

    modport slave (
        input  word_data, word_valid, out_ready,
        output word_ready, seq, valid
    );
endinterface

// File: rtl/serial_seq_transmitter.sv
// rtl/serial_seq_transmitter.sv - MSB-first word serializer with on-demand pattern injection
// Optional even-parity bit per word when SEQ_TX_PARITY_EN is defined.
module serial_seq_transmitter #(
    parameter int          WORD_W      = 8,
    parameter logic [15:0] PATTERN     = 16'b10110,
    parameter int          PATTERN_LEN = 5,
    parameter int          CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_seq_transmitter_if.slave bus_if,
    input  logic                    pattern_req_i,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        words_sent_o,
    output logic [CNT_W-1:0]        patterns_sent_o
);
    localparam int SH_W = 32;
    // Words and the pattern are both left-aligned into one shifter so a single
    // path feeds seq regardless of which frame type is in flight.
    localparam logic [SH_W-1:0] PAT_LOAD =
        SH_W'(PATTERN[PATTERN_LEN-1:0]) << (SH_W - PATTERN_LEN);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_WORD, S_PAT, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WORD, S_PAT} state_t;
`endif

    state_t            state_q,   state_d;
    logic [SH_W-1:0]   sh_q,      sh_d;
    logic [5:0]        cnt_q,     cnt_d;
    logic              pending_q, pending_d;
    logic              seq_q,     seq_d;
    logic              valid_q,   valid_d;
    logic [CNT_W-1:0]  words_q,   words_d;
    logic [CNT_W-1:0]  pats_q,    pats_d;
`ifdef SEQ_TX_PARITY_EN
    logic              parity_q,  parity_d;
`endif

    logic              word_ready;
    logic              xfer;
    logic              enter_pat;
    logic [SH_W-1:0]   word_load;

    always_comb begin
        word_ready = (state_q == S_IDLE) && !pending_q && !reset;
        xfer       = valid_q && bus_if.out_ready;
        enter_pat  = (state_q == S_IDLE) && pending_q;
        word_load  = SH_W'(bus_if.word_data) << (SH_W - WORD_W);

        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        valid_d   = valid_q;
        words_d   = words_q;
        pats_d    = pats_q;
`ifdef SEQ_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        // A request on the very edge PAT is entered re-arms the flag so it is never lost.
        pending_d = pattern_req_i || (pending_q && !enter_pat);

        case (state_q)
            S_IDLE: begin
                if (enter_pat) begin
                    state_d = S_PAT;
                    seq_d   = PAT_LOAD[SH_W-1];
                    sh_d    = PAT_LOAD << 1;
                    cnt_d   = 6'(PATTERN_LEN - 1);
                    valid_d = 1'b1;
                end else if (bus_if.word_valid && word_ready) begin
                    state_d  = S_WORD;
                    seq_d    = word_load[SH_W-1];
                    sh_d     = word_load << 1;
                    cnt_d    = 6'(WORD_W - 1);
                    valid_d  = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    parity_d = ^bus_if.word_data;
`endif
                end
            end
            S_WORD, S_PAT: begin
                if (xfer) begin
                    if (cnt_q != 6'd0) begin
                        seq_d = sh_q[SH_W-1];
                        sh_d  = sh_q << 1;
                        cnt_d = cnt_q - 6'd1;
                    end else if (state_q == S_PAT) begin
                        pats_d  = pats_q + CNT_W'(1);
                        state_d = S_IDLE;
                        seq_d   = 1'b0;
                        valid_d = 1'b0;
                    end else begin
`ifdef SEQ_TX_PARITY_EN
                        state_d = S_PAR;
                        seq_d   = parity_q;
`else
                        words_d = words_q + CNT_W'(1);
                        state_d = S_IDLE;
                        seq_d   = 1'b0;
                        valid_d = 1'b0;
`endif
                    end
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                if (xfer) begin
                    words_d = words_q + CNT_W'(1);
                    state_d = S_IDLE;
                    seq_d   = 1'b0;
                    valid_d = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            seq_q     <= 1'b0;
            valid_q   <= 1'b0;
            words_q   <= '0;
            pats_q    <= '0;
`ifdef SEQ_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            words_q   <= words_d;
            pats_q    <= pats_d;
`ifdef SEQ_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus_if.word_ready = word_ready;
    assign bus_if.seq        = seq_q;
    assign bus_if.valid      = valid_q;
    assign busy_o            = (state_q != S_IDLE) || pending_q;
    assign words_sent_o      = words_q;
    assign patterns_sent_o   = pats_q;
endmodule

// File: tb/tb_serial_seq_transmitter.sv
// tb/tb_serial_seq_transmitter.sv - scoreboard bench for serial_seq_transmitter
module tb_serial_seq_transmitter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pattern_req = 1'b0;
    logic        busy;
    logic [15:0] words_sent;
    logic [15:0] patterns_sent;

    serial_seq_transmitter_if #(.WORD_W(8)) bus ();

    serial_seq_transmitter dut (
        .clk             (clk),
        .reset           (reset),
        .bus_if          (bus),
        .pattern_req_i   (pattern_req),
        .busy_o          (busy),
        .words_sent_o    (words_sent),
        .patterns_sent_o (patterns_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
        logic pat;
    } exp_t;

    localparam logic [4:0] PAT_BITS = 5'b10110;

    exp_t        q[$];
    exp_t        e;
    logic        pend = 1'b0;
    int unsigned m_words = 0;
    int unsigned m_pats = 0;
    int          stall = 0;
    logic        started = 1'b0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_seq = 1'b0;
    logic        prev_reset = 1'b1, prev_last = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_word(input logic [7:0] w);
        for (int k = 7; k >= 0; k--) begin
`ifdef SEQ_TX_PARITY_EN
            q.push_back('{b: w[k], last: 1'b0, pat: 1'b0});
`else
            q.push_back('{b: w[k], last: (k == 0), pat: 1'b0});
`endif
        end
`ifdef SEQ_TX_PARITY_EN
        q.push_back('{b: ^w, last: 1'b1, pat: 1'b0});
`endif
    endfunction

    function automatic void push_pat();
        logic [4:0] p;
        p = PAT_BITS;
        for (int k = 4; k >= 0; k--)
            q.push_back('{b: p[k], last: (k == 0), pat: 1'b1});
    endfunction

    // Monitor and reference model: checks present outputs, then advances the
    // frame-level model by what the upcoming rising edge will sample.
    always @(negedge clk) begin
        if (started) begin
            chk("word_ready", {31'd0, bus.word_ready}, {31'd0, (!reset && q.size() == 0 && !pend)});
            chk("busy", {31'd0, busy}, {31'd0, (q.size() != 0 || pend)});
            chk("words_sent", {16'd0, words_sent}, m_words & 32'hFFFF);
            chk("patterns_sent", {16'd0, patterns_sent}, m_pats & 32'hFFFF);
            if (prev_reset || prev_last) begin
                chk("bubble_valid", {31'd0, bus.valid}, 32'd0);
            end else if (prev_valid && !prev_ready) begin
                chk("hold_valid", {31'd0, bus.valid}, 32'd1);
                chk("hold_seq", {31'd0, bus.seq}, {31'd0, prev_seq});
            end

            prev_last = 1'b0;
            if (reset) begin
                q.delete();
                pend    = 1'b0;
                m_words = 0;
                m_pats  = 0;
                stall   = 0;
            end else begin
                if (bus.valid && bus.out_ready) begin
                    stall = 0;
                    if (q.size() == 0) begin
                        chk("unexpected_bit", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("seq", {31'd0, bus.seq}, {31'd0, e.b});
                        if (e.last) begin
                            prev_last = 1'b1;
                            if (e.pat) m_pats++;
                            else m_words++;
                        end
                    end
                end else if (q.size() != 0 && bus.out_ready) begin
                    stall++;
                    chk("start_latency", stall, (stall <= 1) ? stall : 32'd1);
                end
                if (bus.word_valid && bus.word_ready) push_word(bus.word_data);
                if (pattern_req) begin
                    if (q.size() == 0 && !pend) push_pat();
                    else pend = 1'b1;
                end
                if (q.size() == 0 && pend) begin
                    push_pat();
                    pend = 1'b0;
                end
            end
        end
        prev_valid = bus.valid;
        prev_ready = bus.out_ready;
        prev_seq   = bus.seq;
        prev_reset = reset;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.word_data  = 8'h00;
        bus.word_valid = 1'b0;
        bus.out_ready  = 1'b1;
        reset          = 1'b1;
        cyc(1);
        started = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);

        bus.word_data = 8'hA5; bus.word_valid = 1'b1;
        cyc(1);
        bus.word_valid = 1'b0;
        cyc(12);

        pattern_req = 1'b1;
        cyc(1);
        pattern_req = 1'b0;
        cyc(10);

        bus.word_data = 8'h3C; bus.word_valid = 1'b1;
        cyc(1);
        bus.word_valid = 1'b0;
        cyc(4);
        bus.out_ready = 1'b0;
        cyc(3);
        bus.out_ready = 1'b1;
        cyc(10);

        bus.word_data = 8'h55; bus.word_valid = 1'b1;
        cyc(1);
        bus.word_valid = 1'b0;
        cyc(2);
        pattern_req = 1'b1; cyc(1); pattern_req = 1'b0;
        cyc(2);
        pattern_req = 1'b1; cyc(1); pattern_req = 1'b0;
        cyc(20);

        bus.word_data = 8'hFF; bus.word_valid = 1'b1;
        cyc(1);
        bus.word_valid = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.word_data = 8'h01; bus.word_valid = 1'b1;
        cyc(1);
        bus.word_valid = 1'b0;
        cyc(12);

        for (int i = 0; i < 3000; i++) begin
            bus.word_valid = ($urandom_range(0, 3) != 0);
            bus.word_data  = 8'($urandom);
            pattern_req    = ($urandom_range(0, 19) == 0);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 399) == 0);
            cyc(1);
        end

        bus.word_valid = 1'b0;
        pattern_req    = 1'b0;
        reset          = 1'b0;
        bus.out_ready  = 1'b1;
        cyc(60);
        chk("drained_queue", q.size(), 32'd0);
        chk("drained_pending", {31'd0, pend}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
